// File: rtl/stopwatch_counter.sv
// stopwatch_counter
//   Counts 1 ms strobes into a BCD mm:ss.cc time value with run/pause/clear
//   control and a lap (display freeze) function. Feeds the 7-segment driver.
//
//   State table:
//   state   | meaning
//   S_IDLE  | time is zero, counting stopped
//   S_RUN   | counting 1 ms strobes
//   S_PAUSE | counting stopped, value held
//
// Ports:
//   I_CLK      system clock
//   I_RST      asynchronous, active-high reset
//   I_EN_1MS   single-cycle 1 ms strobe
//   I_START    start/pause toggle pulse
//   I_CLEAR    zero-the-time pulse (ignored while running)
//   I_LAP      lap freeze/release toggle pulse
//   O_CS_L .. O_MIN_H   displayed BCD digits
//   O_RUN      high while running
//   O_LAP      high while the display is frozen
//   O_OVF      one-cycle pulse on wrap 59:59.99 -> 00:00.00
module stopwatch_counter #(
   parameter int MS_PER_TICK = 10
) (
   input  logic       I_CLK,
   input  logic       I_RST,
   input  logic       I_EN_1MS,
   input  logic       I_START,
   input  logic       I_CLEAR,
   input  logic       I_LAP,
   output logic [3:0] O_CS_L,
   output logic [3:0] O_CS_H,
   output logic [3:0] O_SEC_L,
   output logic [3:0] O_SEC_H,
   output logic [3:0] O_MIN_L,
   output logic [3:0] O_MIN_H,
   output logic       O_RUN,
   output logic       O_LAP,
   output logic       O_OVF
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

   // Digit packing, MSB first: {MIN_H, MIN_L, SEC_H, SEC_L, CS_H, CS_L}
   localparam logic [23:0] DIGIT_MAX  = 24'h595999;
   localparam logic [7:0]  PRESC_LAST = 8'(MS_PER_TICK - 1);

   state_t      state_q, state_d;
   logic [7:0]  presc_q, presc_d;
   logic [23:0] cnt_q, cnt_d;
   logic [23:0] disp_q, disp_d;
   logic        lap_q, lap_d;
   logic        ovf_q, ovf_d;
   logic        clear_acc;
   logic        count_en;
   logic        tick;
   logic        carry;
   logic        snap;

   always_comb begin
      state_d   = state_q;
      clear_acc = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (I_CLEAR)      clear_acc = 1'b1;
            else if (I_START) state_d   = S_RUN;
         end
         S_RUN: begin
            if (I_START) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (I_CLEAR) begin
               clear_acc = 1'b1;
               state_d   = S_IDLE;
            end else if (I_START) begin
               state_d = S_RUN;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counting looks at the registered state only, so a strobe in the cycle
   // that pauses still counts and one in the cycle that starts does not.
   assign count_en = (state_q == S_RUN) && I_EN_1MS;

   always_comb begin
      presc_d = presc_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      if (clear_acc) begin
         presc_d = '0;
         cnt_d   = '0;
      end else if (count_en) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end
      // Ripple carry through all six digits in one cycle; a carry out of
      // MIN_H is the wrap.
      carry = tick;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            if (cnt_q[4*i +: 4] == DIGIT_MAX[4*i +: 4]) begin
               cnt_d[4*i +: 4] = 4'd0;
            end else begin
               cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
               carry           = 1'b0;
            end
         end
      end
      ovf_d = carry;
   end

   always_comb begin
      lap_d = lap_q;
      snap  = 1'b0;
      if (clear_acc) begin
         lap_d = 1'b0;
      end else if (I_LAP) begin
         if (lap_q) begin
            lap_d = 1'b0;
         end else if (state_q == S_RUN) begin
            lap_d = 1'b1;
            snap  = 1'b1;
         end
      end
      // Display loads the next internal value so a tick shows one cycle
      // after the strobe that completed it.
      disp_d = (!lap_d || snap) ? cnt_d : disp_q;
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
         lap_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
         lap_q   <= lap_d;
         ovf_q   <= ovf_d;
      end
   end

   assign O_CS_L  = disp_q[3:0];
   assign O_CS_H  = disp_q[7:4];
   assign O_SEC_L = disp_q[11:8];
   assign O_SEC_H = disp_q[15:12];
   assign O_MIN_L = disp_q[19:16];
   assign O_MIN_H = disp_q[23:20];
   assign O_RUN   = (state_q == S_RUN);
   assign O_LAP   = lap_q;
   assign O_OVF   = ovf_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Testbench for stopwatch_counter: integer-time reference model checked every
// cycle, plus literal expectations at key points of each scenario.
module tb_stopwatch_counter;

   localparam int MS = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       en, start, clear, lap;
   logic [3:0] cs_l, cs_h, sec_l, sec_h, min_l, min_h;
   logic       o_run, o_lap, o_ovf;

   int errors = 0;
   int checks = 0;
   int ovf_cnt = 0;
   int ovf_base;
   bit chk_en = 1'b0;

   // reference model: time as total centiseconds
   int m_state;   // 0 idle, 1 run, 2 pause
   int m_ms;
   int m_cs;
   int m_disp;
   bit m_lap;
   bit m_ovf;
   bit preload_req = 1'b0;
   int preload_val = 0;

   stopwatch_counter #(.MS_PER_TICK(MS)) dut (
      .I_CLK   (clk),
      .I_RST   (rst),
      .I_EN_1MS(en),
      .I_START (start),
      .I_CLEAR (clear),
      .I_LAP   (lap),
      .O_CS_L  (cs_l),
      .O_CS_H  (cs_h),
      .O_SEC_L (sec_l),
      .O_SEC_H (sec_h),
      .O_MIN_L (min_l),
      .O_MIN_H (min_h),
      .O_RUN   (o_run),
      .O_LAP   (o_lap),
      .O_OVF   (o_ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] to_bcd(input int t);
      int c, s, m;
      c = t % 100;
      s = (t / 100) % 60;
      m = t / 6000;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or posedge rst) begin : model
      bit run;
      if (rst) begin
         m_state = 0; m_ms = 0; m_cs = 0; m_disp = 0; m_lap = 0; m_ovf = 0;
      end else begin
         run   = (m_state == 1);
         m_ovf = 0;
         if (clear && m_state != 1) begin
            m_state = 0; m_ms = 0; m_cs = 0; m_lap = 0;
         end else begin
            if (preload_req) m_cs = preload_val;
            if (run && en) begin
               m_ms++;
               if (m_ms == MS) begin
                  m_ms = 0;
                  m_cs++;
                  if (m_cs == 360000) begin
                     m_cs  = 0;
                     m_ovf = 1;
                  end
               end
            end
            if (start) m_state = run ? 2 : 1;
            if (lap) begin
               if (m_lap) m_lap = 0;
               else if (run) begin
                  m_lap  = 1;
                  m_disp = m_cs;
               end
            end
         end
         if (!m_lap) m_disp = m_cs;
      end
   end

   always @(negedge clk) begin
      if (o_ovf === 1'b1) ovf_cnt++;
      if (chk_en) begin
         chk("display", {min_h, min_l, sec_h, sec_l, cs_h, cs_l}, to_bcd(m_disp));
         chk("run", o_run, m_state == 1);
         chk("lap", o_lap, m_lap);
         chk("ovf", o_ovf, m_ovf);
      end
   end

   task automatic pulse(input bit s, input bit c, input bit l);
      start = s; clear = c; lap = l;
      @(negedge clk);
      start = 0; clear = 0; lap = 0;
   endtask

   task automatic strobes(input int n, input int gap);
      repeat (n) begin
         en = 1'b1;
         @(negedge clk);
         en = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
   endtask

   function automatic logic [23:0] disp_now();
      return {min_h, min_l, sec_h, sec_l, cs_h, cs_l};
   endfunction

   initial begin
      rst = 1'b1; en = 0; start = 0; clear = 0; lap = 0;
      repeat (2) @(negedge clk);
      chk("reset_display", disp_now(), 24'h000000);
      chk("reset_run", o_run, 1'b0);
      chk("reset_lap", o_lap, 1'b0);
      chk("reset_ovf", o_ovf, 1'b0);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);

      // 1: 1000 strobes at 1 per 16 clocks
      pulse(1, 0, 0);
      strobes(1000, 16);
      chk("t1_display", disp_now(), 24'h000100);
      chk("t1_run", o_run, 1'b1);
      chk("t1_no_ovf", ovf_cnt, 0);

      // 2: pause keeps partial prescaler, ignores strobes
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      pulse(1, 0, 0);
      strobes(25, 2);
      pulse(1, 0, 0);
      strobes(30, 2);
      pulse(1, 0, 0);
      strobes(5, 2);
      chk("t2_display", disp_now(), 24'h000003);
      chk("t2_run", o_run, 1'b1);

      // 3: clear ignored in RUN; start+clear in RUN pauses; in PAUSE clears
      pulse(0, 1, 0);
      strobes(10, 2);
      chk("t3_clear_ignored", disp_now(), 24'h000004);
      pulse(1, 1, 0);
      chk("t3_run_start_wins", o_run, 1'b0);
      chk("t3_run_no_clear", disp_now(), 24'h000004);
      pulse(1, 1, 0);
      chk("t3_pause_clear_wins", disp_now(), 24'h000000);
      chk("t3_idle_run", o_run, 1'b0);

      // 4: wrap. Strobe in the starting cycle is not counted.
      en = 1'b1;
      pulse(1, 0, 0);
      en = 1'b0;
      pulse(1, 0, 0);
      pulse(0, 0, 1);
      chk("t4_lap_ignored_pause", o_lap, 1'b0);
      force dut.cnt_q = 24'h595999;
      preload_req = 1'b1;
      preload_val = 359999;
      @(negedge clk);
      preload_req = 1'b0;
      release dut.cnt_q;
      ovf_base = ovf_cnt;
      pulse(1, 0, 0);
      strobes(9, 2);
      chk("t4_before_wrap", disp_now(), 24'h595999);
      strobes(1, 1);
      chk("t4_wrap_display", disp_now(), 24'h000000);
      chk("t4_wrap_ovf", o_ovf, 1'b1);
      @(negedge clk);
      chk("t4_ovf_single", ovf_cnt - ovf_base, 1);
      chk("t4_run_kept", o_run, 1'b1);

      // 5: lap freeze and release
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      pulse(1, 0, 0);
      strobes(500, 2);
      pulse(0, 0, 1);
      strobes(200, 2);
      chk("t5_frozen", disp_now(), 24'h000050);
      chk("t5_lap_on", o_lap, 1'b1);
      pulse(0, 0, 1);
      chk("t5_released", disp_now(), 24'h000070);
      chk("t5_lap_off", o_lap, 1'b0);

      // 6: async reset while lapped at 00:12.34
      pulse(1, 0, 0);
      pulse(0, 1, 0);
      pulse(1, 0, 0);
      strobes(12340, 1);
      pulse(0, 0, 1);
      chk("t6_before_reset", disp_now(), 24'h001234);
      chk("t6_lap_before", o_lap, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk("t6_async_display", disp_now(), 24'h000000);
      chk("t6_async_lap", o_lap, 1'b0);
      chk("t6_async_run", o_run, 1'b0);
      chk("t6_async_ovf", o_ovf, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
